// File: rtl/pe_result_drain_if.sv
// pe_result_drain_if: valid/ready stream of requantised PE results with element index and last flag.
interface pe_result_drain_if #(
    parameter int OUT_W = 8
);
    logic             m_valid;
    logic             m_ready;
    logic [OUT_W-1:0] m_data;
    logic [3:0]       m_idx;
    logic             m_last;

    modport master(output m_valid, m_data, m_idx, m_last, input m_ready);
    modport slave(input m_valid, m_data, m_idx, m_last, output m_ready);
endinterface

// File: rtl/pe_result_drain.sv
// pe_result_drain: sweeps the PE result mux, round-shifts, optional ReLU, saturates to int8 and streams out.
// Optional macro DRAIN_BIAS_EN adds a bias input latched at start and added before rounding.
module pe_result_drain #(
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 8,
    parameter int NUM_PE  = 16,
    parameter int SHIFT_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [SHIFT_W-1:0]      shift,
    input  logic                    relu_en,
    output logic [3:0]              out_sel,
    input  logic signed [ACC_W-1:0] result,
`ifdef DRAIN_BIAS_EN
    input  logic signed [ACC_W-1:0] bias,
`endif
    output logic                    busy,
    output logic                    done,
    pe_result_drain_if.master       m
);
`ifdef DRAIN_BIAS_EN
    localparam int IW = ACC_W + 2;
`else
    localparam int IW = ACC_W + 1;
`endif

    typedef enum logic [1:0] {IDLE, SWEEP, FLUSH} state_t;
    state_t state, state_n;

    logic [SHIFT_W-1:0] shift_q;
    logic               relu_q;
    logic signed [IW-1:0] sum, rnd, scaled, clamped;
    logic [OUT_W-1:0]   sat;
    logic               cap, xfer, last_idx;
`ifdef DRAIN_BIAS_EN
    logic signed [ACC_W-1:0] bias_q;
`endif

    assign cap      = !m.m_valid || m.m_ready;
    assign xfer     = m.m_valid && m.m_ready;
    assign last_idx = out_sel == 4'(NUM_PE - 1);

    // One guard bit above the accumulator keeps the rounding add from wrapping
    always_comb begin
`ifdef DRAIN_BIAS_EN
        sum = IW'(result) + IW'(bias_q);
`else
        sum = IW'(result);
`endif
        rnd = (shift_q == '0) ? '0 : IW'(1) << (shift_q - SHIFT_W'(1));
        scaled = (sum + rnd) >>> shift_q;
        clamped = (relu_q && scaled[IW-1]) ? '0 : scaled;
        sat = (&clamped[IW-1:OUT_W-1] || ~|clamped[IW-1:OUT_W-1]) ? clamped[OUT_W-1:0]
            : {clamped[IW-1], {(OUT_W-1){~clamped[IW-1]}}};
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? SWEEP : IDLE;
            SWEEP:   state_n = (cap && last_idx) ? FLUSH : SWEEP;
            FLUSH:   state_n = xfer ? IDLE : FLUSH;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sel   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            m.m_valid <= 1'b0;
            m.m_data  <= '0;
            m.m_idx   <= '0;
            m.m_last  <= 1'b0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
`ifdef DRAIN_BIAS_EN
            bias_q    <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                shift_q <= shift;
                relu_q  <= relu_en;
`ifdef DRAIN_BIAS_EN
                bias_q  <= bias;
`endif
                out_sel <= '0;
                busy    <= 1'b1;
            end
            // Output register only reloads when empty or being drained, so a stall freezes it
            if (state == SWEEP && cap) begin
                m.m_valid <= 1'b1;
                m.m_data  <= sat;
                m.m_idx   <= out_sel;
                m.m_last  <= last_idx;
                if (!last_idx) out_sel <= out_sel + 4'd1;
            end
            if (state == FLUSH && xfer) begin
                m.m_valid <= 1'b0;
                done      <= 1'b1;
                busy      <= 1'b0;
                out_sel   <= '0;
            end
        end
    end
endmodule
